// File: rtl/tri_bus_arbiter.sv
// N-channel tri-state bus driver with a round-robin arbiter and a one-cycle all-Z turnaround.
// Optional overlap checker compiled in with `define BUS_CONTENTION_CHECK_EN.
module tri_bus_arbiter #(
  parameter int WIDTH    = 8,
  parameter int N        = 4,
  parameter int HOLD_MAX = 4
) (
  input  logic                                clock,
  input  logic                                reset_b,
  input  logic [N-1:0]                        req,
  input  logic [N*WIDTH-1:0]                  data_in,
  output logic [N-1:0]                        grant,
  output tri   [WIDTH-1:0]                    bus_out,
  output logic                                bus_valid,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] owner,
  output logic                                contention
);

  localparam int OW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  grant_nxt;
  logic [OW-1:0] owner_nxt, last, last_nxt, sel;
  logic [HW-1:0] hold, hold_nxt;
  logic          any_req;
  int            idx;

  // Round-robin pick: first requester after the previous owner, wrapping modulo N.
  always_comb begin
    any_req = 1'b0;
    sel     = '0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        sel     = OW'(idx);
      end
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    owner_nxt = owner;
    last_nxt  = last;
    hold_nxt  = hold;
    unique case (state)
      IDLE, TURN: begin
        if (any_req) begin
          state_nxt = DRIVE;
          grant_nxt = N'(1) << sel;
          owner_nxt = sel;
          last_nxt  = sel;
          hold_nxt  = HW'(1);
        end else begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      end
      DRIVE: begin
        // Other requesters never preempt; only release or hold exhaustion ends ownership.
        if (!req[owner] || hold == HW'(HOLD_MAX)) begin
          state_nxt = TURN;
          grant_nxt = '0;
        end else begin
          hold_nxt = hold + HW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state <= IDLE;
      grant <= '0;
      owner <= '0;
      last  <= OW'(N - 1);
      hold  <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      hold  <= hold_nxt;
    end
  end

  assign bus_valid = (state == DRIVE);

  // One bufif1 per bit per channel; the async-reset grant drops the enables without a clock edge.
  for (genvar i = 0; i < N; i++) begin : g_chan
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      bufif1 u_drv (bus_out[b], data_in[i*WIDTH+b], grant[i]);
    end
  end

`ifdef BUS_CONTENTION_CHECK_EN
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      contention <= 1'b0;
    end else if ($countones(grant) > 1 || (state == DRIVE && $isunknown(bus_out))) begin
      contention <= 1'b1;
      $display("%0t: bus contention, grant=%b", $time, grant);
    end
  end
`else
  assign contention = 1'b0;
`endif

endmodule

// File: doc/tri_bus_arbiter.md
Name: tri_bus_arbiter

Overview:
Parametrised N-channel tri-state bus driver with a round-robin arbiter. It generalises the 2:1 bufif-based tri-state mux to N sources of WIDTH bits. Each channel drives a shared tri bus through its own bufif1 bank, and the enables come from a registered grant. A mandatory one-cycle all-Z turnaround between owners guarantees that no two drivers ever overlap.

Parameters:
WIDTH, 8, data width of each channel and of the bus
N, 4, number of requesting channels (2..16)
HOLD_MAX, 4, maximum consecutive DRIVE cycles per grant before a forced turnaround (1..255)

Ports:
clock  input  1  rising-edge clock
reset_b  input  1  asynchronous active-low reset
req  input  N  per-channel bus request, level-sensitive
data_in  input  N*WIDTH  channel i data on bits [i*WIDTH +: WIDTH]
grant  output  N  one-hot registered grant; all zeros when no owner
bus_out  output (tri)  WIDTH  shared bus, driven only by the granted channel, otherwise Z
bus_valid  output  1  high while in DRIVE
owner  output  clog2(N) (min 1)  index of the current or most recent owner
contention  output  1  sticky overlap-error flag (see Optional Feature)

Behaviour:
- Reset (asynchronous, reset_b=0):
  - state=IDLE, grant=0, bus_out=Z on all bits, bus_valid=0, owner=0.
  - Round-robin pointer last=N-1, so channel 0 has first priority.
  - Hold counter=0, contention=0.
  - Reset asserted mid-DRIVE releases the bus to Z immediately, without waiting for a clock edge.
- Bus drive:
  - Channel i drives bus_out = data_in[i] through bufif1, enabled by grant[i].
  - The path is combinational while granted, so data changes propagate in the same cycle.
- State IDLE:
  - If any req bit is 1 at the edge, select the first set bit searching last+1, last+2, ... modulo N.
  - Set grant=onehot(sel), owner=sel, last=sel, hold=1, and go to DRIVE.
  - Latency: req sampled at edge k gives grant and the driven bus after edge k.
  - Otherwise stay in IDLE.
- State DRIVE: bus_valid=1. At each edge:
  - If req[owner]=0 or hold==HOLD_MAX: grant<=0 and go to TURN.
  - Otherwise hold<=hold+1 and stay in DRIVE.
  - req bits of other channels do not preempt the owner.
- State TURN:
  - Exactly one cycle with grant=0, bus_out=Z, bus_valid=0.
  - At the edge, arbitrate as in IDLE: go to DRIVE with a new grant if any req is set, else go to IDLE.
  - The previous owner may be re-granted only if no other channel is requesting (the pointer has advanced past it).
- Simultaneous requests are resolved strictly by the round-robin order. Three channels requesting continuously are served in order 0,1,2,0,...
- A requester whose req drops before it is granted is simply skipped. No request latching.
- Hold counter width is clog2(HOLD_MAX+1). It never wraps, because reaching HOLD_MAX forces TURN.
- owner retains its last value through TURN and IDLE.
- Invariant: popcount(grant) ≤ 1 at all times, and grant≠0 only in DRIVE.

Optional Feature:
- Macro BUS_CONTENTION_CHECK_EN.
- When defined:
  - Each cycle, check that popcount(grant) ≤ 1.
  - In DRIVE, also check that bus_out contains no X or Z bits.
  - Any violation sets contention=1, which is sticky until reset, and issues $display with $time and grant.
- When undefined: contention is tied to 0 and no checking logic is compiled.

Test Plan:
- Reset with req=4'b1111 held: grant=0 and bus_out=8'hzz during reset. First edge after release gives grant=4'b0001, owner=0, bus_out=data_in[0].
- N=4, HOLD_MAX=4, req=4'b0101 held, data_in ch0=8'hA5, ch2=8'h3C. Required sequence:
  - ch0 drives 8'hA5 for 4 cycles, then 1 Z cycle.
  - ch2 drives 8'h3C for 4 cycles, then 1 Z cycle.
  - ch0 again. Never two grant bits at once.
- Only req[1] is pulsed for 2 cycles: grant=4'b0010 for 2 cycles, one TURN cycle, then IDLE with bus Z and owner=1 retained.
- req[3] is held alone for 10 cycles with HOLD_MAX=4: DRIVE 4, TURN 1, DRIVE 4, TURN 1. The same owner is re-granted because no one else is requesting.
- reset_b dropped mid-DRIVE, between edges: bus_out goes Z and grant goes 0 immediately. After release, arbitration restarts from channel 0.
- With BUS_CONTENTION_CHECK_EN, a testbench force of grant=4'b0011 sets contention=1 and prints a message. With the macro undefined, contention stays 0 throughout all scenarios.
